// File: rtl/dpram_port_arbiter_if.sv
// Request/response and RAM-side signal bundle for dpram_port_arbiter.
// slave  = the arbiter; master = the clients plus the dual-port RAM.
interface dpram_port_arbiter_if #(
    parameter int DATA_W = 128,
    parameter int ADDR_W = 3
);
    // Client requests
    logic              req_valid_a, req_valid_b;
    logic              req_ready_a, req_ready_b;
    logic              req_we_a,    req_we_b;
    logic [ADDR_W-1:0] req_addr_a,  req_addr_b;
    logic [DATA_W-1:0] req_wdata_a, req_wdata_b;
    // Client read responses
    logic              rsp_valid_a, rsp_valid_b;
    logic [DATA_W-1:0] rsp_rdata_a, rsp_rdata_b;
    // RAM ports
    logic              ram_wr_en_a, ram_wr_en_b;
    logic [ADDR_W-1:0] ram_addr_a,  ram_addr_b;
    logic [DATA_W-1:0] ram_din_a,   ram_din_b;
    logic [DATA_W-1:0] ram_dout_a,  ram_dout_b;

    modport slave (
        input  req_valid_a, req_valid_b, req_we_a, req_we_b,
        input  req_addr_a, req_addr_b, req_wdata_a, req_wdata_b,
        output req_ready_a, req_ready_b,
        output rsp_valid_a, rsp_valid_b, rsp_rdata_a, rsp_rdata_b,
        output ram_wr_en_a, ram_wr_en_b, ram_addr_a, ram_addr_b,
        output ram_din_a, ram_din_b,
        input  ram_dout_a, ram_dout_b
    );

    modport master (
        output req_valid_a, req_valid_b, req_we_a, req_we_b,
        output req_addr_a, req_addr_b, req_wdata_a, req_wdata_b,
        input  req_ready_a, req_ready_b,
        input  rsp_valid_a, rsp_valid_b, rsp_rdata_a, rsp_rdata_b,
        input  ram_wr_en_a, ram_wr_en_b, ram_addr_a, ram_addr_b,
        input  ram_din_a, ram_din_b,
        output ram_dout_a, ram_dout_b
    );
endinterface

// File: rtl/dpram_port_arbiter.sv
// Two-client front-end for a dual-port RAM with one-cycle registered read.
// Each client owns one RAM port; same-address collisions involving a write
// are serialized with round-robin priority, and a saturating counter
// records how many collision cycles occurred.
module dpram_port_arbiter #(
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    dpram_port_arbiter_if.slave bus,
    output logic [CNT_W-1:0]   collision_cnt
);

    typedef enum logic {
        PRIO_A = 1'b0,
        PRIO_B = 1'b1
    } prio_e;

    prio_e            prio_q,      prio_d;
    logic             rd_pend_a_q, rd_pend_a_d;
    logic             rd_pend_b_q, rd_pend_b_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;

    logic collision;
    logic ready_a, ready_b;
    logic fire_a,  fire_b;

    // Arbitration, RAM issue, response formatting and next-state logic.
    always_comb begin
        // NOTE: every signal gets a default before any branch so no path can leave it unassigned and infer a latch.
        prio_d      = prio_q;
        cnt_d       = cnt_q;

        // Two reads to one address are harmless; any write makes it a collision.
        collision   = bus.req_valid_a && bus.req_valid_b
                      && (bus.req_addr_a == bus.req_addr_b)
                      && (bus.req_we_a || bus.req_we_b);

        // Ready is held low while reset is asserted so nothing issues.
        ready_a     = rst_n && (!collision || (prio_q == PRIO_A));
        ready_b     = rst_n && (!collision || (prio_q == PRIO_B));
        fire_a      = bus.req_valid_a && ready_a;
        fire_b      = bus.req_valid_b && ready_b;

        bus.req_ready_a = ready_a;
        bus.req_ready_b = ready_b;

        // Address and data always pass through; an idle port just does a dummy read.
        bus.ram_addr_a  = bus.req_addr_a;
        bus.ram_addr_b  = bus.req_addr_b;
        bus.ram_din_a   = bus.req_wdata_a;
        bus.ram_din_b   = bus.req_wdata_b;
        bus.ram_wr_en_a = fire_a && bus.req_we_a;
        bus.ram_wr_en_b = fire_b && bus.req_we_b;

        rd_pend_a_d = fire_a && !bus.req_we_a;
        rd_pend_b_d = fire_b && !bus.req_we_b;

        // The loser of a collision wins the next one.
        if (collision) begin
            prio_d = (prio_q == PRIO_A) ? PRIO_B : PRIO_A;
            if (cnt_q != {CNT_W{1'b1}}) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        // Read data lines the RAM's registered output up with the pending flag.
        bus.rsp_valid_a = rd_pend_a_q;
        bus.rsp_valid_b = rd_pend_b_q;
        bus.rsp_rdata_a = rd_pend_a_q ? bus.ram_dout_a : '0;
        bus.rsp_rdata_b = rd_pend_b_q ? bus.ram_dout_b : '0;

        collision_cnt   = cnt_q;
    end

    // State registers: priority, pending-read flags and collision counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_q      <= PRIO_A;
            rd_pend_a_q <= 1'b0;
            rd_pend_b_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values regardless of statement order.
            prio_q      <= prio_d;
            rd_pend_a_q <= rd_pend_a_d;
            rd_pend_b_q <= rd_pend_b_d;
            cnt_q       <= cnt_d;
        end
    end

endmodule

// File: doc/dpram_port_arbiter.md
# dpram_port_arbiter

Request front-end sitting directly upstream of the 8×128 dual-port RAM. Accepts independent valid/ready read/write requests from two clients, issues them onto RAM ports A and B, serializes same-address collisions with round-robin priority, and returns read data with a response-valid strobe aligned to the RAM's one-cycle registered read. Also keeps a saturating collision counter for debug.

## Interface
- DATA_W, 128, data width; matches RAM word
- ADDR_W, 3, address width; matches RAM depth of 8
- CNT_W, 16, collision counter width
- clk  in  1  rising-edge clock shared with RAM
- rst_n  in  1  asynchronous active-low reset
- req_valid_a / req_valid_b  in  1  client request valid
- req_ready_a / req_ready_b  out  1  request accepted this cycle when valid&&ready
- req_we_a / req_we_b  in  1  1 = write, 0 = read
- req_addr_a / req_addr_b  in  ADDR_W  request address
- req_wdata_a / req_wdata_b  in  DATA_W  write data
- rsp_valid_a / rsp_valid_b  out  1  read data valid on rsp_rdata_x
- rsp_rdata_a / rsp_rdata_b  out  DATA_W  read data
- ram_wr_en_a / ram_wr_en_b  out  1  to RAM write enable
- ram_addr_a / ram_addr_b  out  ADDR_W  to RAM address
- ram_din_a / ram_din_b  out  DATA_W  to RAM write data
- ram_dout_a / ram_dout_b  in  DATA_W  from RAM registered read data
- collision_cnt  out  CNT_W  saturating count of collision cycles

## Operation
- Collision: req_valid_a && req_valid_b && req_addr_a == req_addr_b && (req_we_a || req_we_b). Two reads to the same address are not a collision.
- No collision: req_ready_a = req_ready_b = 1 (combinational); each valid request issues on its own port the same cycle.
- Collision: only the port named by prio is ready and issues; the other has ready = 0 and must hold its request stable.
- prio register: reset = A. On a collision cycle, prio flips to the loser at the clock edge. Non-collision cycles leave prio unchanged.
- Issue on port x: ram_addr_x = req_addr_x, ram_din_x = req_wdata_x, ram_wr_en_x = req_valid_x && req_ready_x && req_we_x. Idle port: ram_wr_en_x = 0; addr and din pass through; the RAM read is harmless.
- Reads: rd_pend_x <= req_valid_x && req_ready_x && !req_we_x. rsp_valid_x = rd_pend_x. rsp_rdata_x = rd_pend_x ? ram_dout_x : 0.
- Writes produce no response.
- collision_cnt increments by 1 on each collision cycle and saturates at all-ones.

## Timing
- Accept-to-RAM: 0 cycles (combinational issue).
- Read response: rsp_valid_x is high exactly one cycle after acceptance, for one cycle. Back-to-back reads give back-to-back responses; throughput is 1 request/cycle/port.
- Reset values (asynchronous, while rst_n = 0): rd_pend_a/b = 0, so rsp_valid_a/b = 0 and rsp_rdata_a/b = 0; prio = A; collision_cnt = 0.
- During reset, req_ready and ram_wr_en are forced to 0.
- A reset asserted mid-read drops the pending response; RAM contents are not cleared.
- Persistent collisions alternate the winner: A, B, A, … Each client waits at most 1 cycle per collision.
- Non-colliding writes on different addresses in the same cycle both land.

## Test plan
- Reset then idle: all rsp_valid = 0, collision_cnt = 0, ram_wr_en = 0. Hold rst_n low mid-read: rsp_valid stays 0 the next cycle.
- Write A addr 2 = 0xAA..A, next cycle read B addr 2 → rsp_valid_b high 1 cycle later with rsp_rdata_b = 0xAA..A. rsp_valid_a stays 0.
- Same cycle: A writes addr 5, B writes addr 5, both held.
  - Cycle 0: ready_a = 1, ready_b = 0.
  - Cycle 1: ready_b = 1.
  - Final RAM[5] = B data; collision_cnt = 1.
- A reads addr 1 while B writes addr 1 with prio = B (after the previous test): B wins, then A's read returns the new data. collision_cnt = 2.
- Both ports read addr 3 every cycle for 8 cycles: no stalls, 8 responses per port, collision_cnt unchanged.
- Force 65540 collision cycles: collision_cnt saturates at 0xFFFF; grants keep alternating.
